// File: rtl/pixel_row_accumulator_if.sv
// Pixel stream / row-stage bundle between the raster source, the row accumulator
// and the downstream row integral stage.
interface pixel_row_accumulator_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int COORD_WIDTH = 10
);
    logic                   i_frame_start;
    logic                   i_pixel_valid;
    logic [PIXEL_WIDTH-1:0] i_pixel;
    logic                   o_pixel_ready;
    logic                   o_wen;
    logic [DATA_WIDTH-1:0]  o_fifo_in;
    logic [DATA_WIDTH-1:0]  o_reduction_sum;
    logic [COORD_WIDTH-1:0] o_x;
    logic [COORD_WIDTH-1:0] o_y;
    logic                   o_row_end;
    logic                   o_frame_done;
    logic                   o_overflow;

    modport master (
        output i_frame_start, i_pixel_valid, i_pixel,
        input  o_pixel_ready, o_wen, o_fifo_in, o_reduction_sum,
               o_x, o_y, o_row_end, o_frame_done, o_overflow
    );

    modport slave (
        input  i_frame_start, i_pixel_valid, i_pixel,
        output o_pixel_ready, o_wen, o_fifo_in, o_reduction_sum,
               o_x, o_y, o_row_end, o_frame_done, o_overflow
    );
endinterface

// File: rtl/pixel_row_accumulator.sv
// Integral-image front end: accepts raster pixels, emits running row sums with x/y tags.
// Define ROW_SUM_SATURATE_EN to clamp the row sum at all-ones instead of wrapping.
module pixel_row_accumulator #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int COORD_WIDTH  = 10,
    parameter int ROW_GAP      = 4
) (
    input  logic                      clk_os,
    input  logic                      reset_os,
    pixel_row_accumulator_if.slave    bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMAGE_HEIGHT - 1);
    localparam int                     GAP_W    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    localparam int                     GAP_INIT = (ROW_GAP > 0) ? ROW_GAP - 1 : 0;
    localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(GAP_INIT);

`ifdef ROW_SUM_SATURATE_EN
    function automatic logic [DATA_WIDTH-1:0] sat_row_sum(input logic [DATA_WIDTH:0] full);
        if (full[DATA_WIDTH]) return '1;
        return full[DATA_WIDTH-1:0];
    endfunction
`endif

    logic [1:0]             state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [DATA_WIDTH-1:0]  sum_q, sum_d;
    logic                   ready_q, ready_d;
    logic                   wen_q, wen_d;
    logic [DATA_WIDTH-1:0]  fifo_q, fifo_d, rsum_q, rsum_d;
    logic [COORD_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic                   row_end_q, row_end_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic                   row_last;
    logic                   frame_last;
    logic [DATA_WIDTH-1:0]  row_base;
    logic [DATA_WIDTH:0]    sum_full;
    logic [DATA_WIDTH-1:0]  sum_lim;

    assign accept     = ready_q & bus.i_pixel_valid;
    assign row_last   = (x_q == X_LAST);
    assign frame_last = row_last && (y_q == Y_LAST);
    // Each row restarts from zero at its first pixel, whatever the previous row left behind.
    assign row_base   = (x_q == '0) ? '0 : sum_q;
    assign sum_full   = {1'b0, row_base} + (DATA_WIDTH+1)'(bus.i_pixel);
`ifdef ROW_SUM_SATURATE_EN
    assign sum_lim    = sat_row_sum(sum_full);
`else
    assign sum_lim    = sum_full[DATA_WIDTH-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        x_d       = x_q;
        y_d       = y_q;
        sum_d     = sum_q;
        wen_d     = 1'b0;
        fifo_d    = fifo_q;
        rsum_d    = rsum_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        row_end_d = row_end_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_frame_start) begin
                    state_d = ST_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    wen_d     = 1'b1;
                    fifo_d    = DATA_WIDTH'(bus.i_pixel);
                    rsum_d    = sum_lim;
                    sum_d     = sum_lim;
                    ox_d      = x_q;
                    oy_d      = y_q;
                    row_end_d = row_last;
                    ovf_d     = ovf_q | sum_full[DATA_WIDTH];
                    if (!row_last) begin
                        x_d = x_q + COORD_WIDTH'(1);
                    end else begin
                        x_d = '0;
                        if (frame_last) begin
                            y_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            y_d = y_q + COORD_WIDTH'(1);
                            if (ROW_GAP > 0) begin
                                state_d = ST_GAP;
                                gap_d   = GAP_LAST;
                            end
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_ACTIVE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_ACTIVE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            sum_q     <= '0;
            ready_q   <= 1'b0;
            wen_q     <= 1'b0;
            fifo_q    <= '0;
            rsum_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            row_end_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sum_q     <= sum_d;
            ready_q   <= ready_d;
            wen_q     <= wen_d;
            fifo_q    <= fifo_d;
            rsum_q    <= rsum_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            row_end_q <= row_end_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_pixel_ready   = ready_q;
    assign bus.o_wen           = wen_q;
    assign bus.o_fifo_in       = fifo_q;
    assign bus.o_reduction_sum = rsum_q;
    assign bus.o_x             = ox_q;
    assign bus.o_y             = oy_q;
    assign bus.o_row_end       = row_end_q;
    assign bus.o_frame_done    = done_q;
    assign bus.o_overflow      = ovf_q;
endmodule
